time_digits_driver: RTL and testbench

- Countdown game timer (MM:SS, BCD) plus the pixel-side driver that feeds the 16x32 digit bitmap renderer.
- Per pixel, it outputs which of the four digits covers the pixel, the digit value, the in-cell offsets and an inside flag.
- The bitmap renderer turns these into drawingRequest.
- Sits between the VGA pixel counter / one-second tick generator and the digit bitmap in the HUD path.

---
 rtl/time_digits_driver.sv | 210 +++++++++++++++++++++
 tb/tb_time_digits_driver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_digits_driver.sv
`default_nettype none
// ============================================================================
// Module      : time_digits_driver
// Description : MM:SS BCD countdown game timer plus the pixel-side decode that
//               tells the 16x32 digit bitmap which digit covers the pixel,
//               its value and the in-cell offsets (one register stage).
// Revision    : 1.0 - initial release
// ============================================================================
module time_digits_driver #(
    parameter logic [10:0] TOPLEFT_X = 11'd280,
    parameter logic [10:0] TOPLEFT_Y = 11'd8,
    parameter int          DIGIT_W   = 16,
    parameter int          DIGIT_H   = 32,
    parameter int          GAP       = 4,
    parameter logic [7:0]  INIT_MIN  = 8'h02,
    parameter logic [7:0]  INIT_SEC  = 8'h00
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        oneSecPulse,
    input  logic        startGame,
    input  logic        pauseToggle,
    input  logic        loadTime,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle,
    output logic [3:0]  digit,
    output logic        timeUp,
    output logic        timerRunning
);

    localparam logic [10:0] c_PITCH  = 11'(DIGIT_W + GAP);
    localparam logic [10:0] c_PITCH2 = 11'(2 * (DIGIT_W + GAP));
    localparam logic [10:0] c_PITCH3 = 11'(3 * (DIGIT_W + GAP));
    localparam logic [10:0] c_CELL_W = 11'(DIGIT_W);
    localparam logic [10:0] c_X_END  = TOPLEFT_X + 11'(4 * (DIGIT_W + GAP) - GAP);
    localparam logic [10:0] c_Y_END  = TOPLEFT_Y + 11'(DIGIT_H);
    localparam logic [15:0] c_INIT   = {INIT_MIN, INIT_SEC};

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUNNING = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_time;        // live time {min tens, min ones, sec tens, sec ones}
    logic [15:0] w_time_nxt;
    logic [15:0] r_snap;        // frame-stable copy used by the display
    logic        w_time_up_nxt;

    // BCD decrement with borrow chain; every field wraps to its own maximum
    logic [15:0] w_dec;
    logic        w_b0, w_b1, w_b2;
    logic        w_time_zero;
    logic        w_dec_zero;

    assign w_b0 = (r_time[3:0] == 4'd0);
    assign w_b1 = w_b0 && (r_time[7:4] == 4'd0);
    assign w_b2 = w_b1 && (r_time[11:8] == 4'd0);
    assign w_dec[3:0]   = w_b0 ? 4'd9 : r_time[3:0] - 4'd1;
    assign w_dec[7:4]   = w_b0 ? ((r_time[7:4] == 4'd0) ? 4'd5 : r_time[7:4] - 4'd1)
                               : r_time[7:4];
    assign w_dec[11:8]  = w_b1 ? ((r_time[11:8] == 4'd0) ? 4'd9 : r_time[11:8] - 4'd1)
                               : r_time[11:8];
    assign w_dec[15:12] = w_b2 ? r_time[15:12] - 4'd1 : r_time[15:12];
    assign w_time_zero  = (r_time == 16'h0000);
    assign w_dec_zero   = (w_dec == 16'h0000);

    // Next-state, next-time and timeUp decode; loadTime overrides everything
    always_comb begin
        w_state_nxt   = r_state;
        w_time_nxt    = r_time;
        w_time_up_nxt = 1'b0;
        if (loadTime) begin
            w_state_nxt = S_IDLE;
            w_time_nxt  = c_INIT;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (startGame) begin
                        if (w_time_zero) begin
                            w_state_nxt   = S_EXPIRED;
                            w_time_up_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_RUNNING;
                        end
                    end
                end
                S_RUNNING: begin
                    // A tick coinciding with pauseToggle is applied before pausing
                    if (oneSecPulse && !w_time_zero) begin
                        w_time_nxt = w_dec;
                        if (w_dec_zero) begin
                            w_state_nxt   = S_EXPIRED;
                            w_time_up_nxt = 1'b1;
                        end else if (pauseToggle) begin
                            w_state_nxt = S_PAUSED;
                        end
                    end else if (pauseToggle) begin
                        w_state_nxt = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (pauseToggle) begin
                        w_state_nxt = S_RUNNING;
                    end
                end
                S_EXPIRED: begin
                    w_time_nxt = 16'h0000;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Timer state, live time and the registered status outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= S_IDLE;
            r_time       <= c_INIT;
            timeUp       <= 1'b0;
            timerRunning <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_time       <= w_time_nxt;
            timeUp       <= w_time_up_nxt;
            timerRunning <= (w_state_nxt == S_RUNNING);
        end
    end

    // Display snapshot: refreshed only at frame start so digits never tear
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_snap <= c_INIT;
        end else if (loadTime) begin
            r_snap <= c_INIT;
        end else if (startOfFrame) begin
            r_snap <= r_time;
        end
    end

    // Pixel decode: bounds are checked on raw coordinates before subtracting
    logic        w_in_x, w_in_y, w_inside;
    logic [10:0] w_rel_x, w_cell_x, w_base;
    logic [1:0]  w_k;
    logic [3:0]  w_cell_digit;

    assign w_in_x  = (pixelX >= TOPLEFT_X) && (pixelX < c_X_END);
    assign w_in_y  = (pixelY >= TOPLEFT_Y) && (pixelY < c_Y_END);
    assign w_rel_x = pixelX - TOPLEFT_X;

    // Cell index by comparators, then the in-cell column and digit nibble
    always_comb begin
        w_k          = 2'd0;
        w_base       = 11'd0;
        w_cell_digit = 4'd0;
        if (w_rel_x < c_PITCH) begin
            w_k    = 2'd0;
            w_base = 11'd0;
        end else if (w_rel_x < c_PITCH2) begin
            w_k    = 2'd1;
            w_base = c_PITCH;
        end else if (w_rel_x < c_PITCH3) begin
            w_k    = 2'd2;
            w_base = c_PITCH2;
        end else begin
            w_k    = 2'd3;
            w_base = c_PITCH3;
        end
        case (w_k)
            2'd0:    w_cell_digit = r_snap[15:12];
            2'd1:    w_cell_digit = r_snap[11:8];
            2'd2:    w_cell_digit = r_snap[7:4];
            default: w_cell_digit = r_snap[3:0];
        endcase
    end

    assign w_cell_x = w_rel_x - w_base;
    assign w_inside = w_in_x && w_in_y && (w_cell_x < c_CELL_W);

    // One register stage on the pixel outputs; zeros outside every cell
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            offsetX         <= 11'd0;
            offsetY         <= 11'd0;
            InsideRectangle <= 1'b0;
            digit           <= 4'd0;
        end else if (w_inside) begin
            offsetX         <= w_cell_x;
            offsetY         <= pixelY - TOPLEFT_Y;
            InsideRectangle <= 1'b1;
            digit           <= w_cell_digit;
        end else begin
            offsetX         <= 11'd0;
            offsetY         <= 11'd0;
            InsideRectangle <= 1'b0;
            digit           <= 4'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_time_digits_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_digits_driver
// Description : Directed self-checking bench for time_digits_driver. Instance
//               A uses the default 02:00 reload, instance B reloads 10:00 and
//               shares all inputs to exercise the minutes borrow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_digits_driver;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        sof = 1'b0, tick = 1'b0, sg = 1'b0, pt = 1'b0, lt = 1'b0;
    logic [10:0] pixelX = 11'd0, pixelY = 11'd0;

    logic [10:0] a_offsetX, a_offsetY, b_offsetX, b_offsetY;
    logic        a_inside, a_timeUp, a_running, b_inside, b_timeUp, b_running;
    logic [3:0]  a_digit, b_digit;

    int n_tests = 0;
    int n_fail  = 0;
    int n_timeup = 0;

    logic [15:0] ta, tbv;

    time_digits_driver u_dut_a (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .oneSecPulse(tick),
        .startGame(sg), .pauseToggle(pt), .loadTime(lt),
        .pixelX(pixelX), .pixelY(pixelY),
        .offsetX(a_offsetX), .offsetY(a_offsetY), .InsideRectangle(a_inside),
        .digit(a_digit), .timeUp(a_timeUp), .timerRunning(a_running)
    );

    time_digits_driver #(.INIT_MIN(8'h10), .INIT_SEC(8'h00)) u_dut_b (
        .clk(clk), .resetN(resetN), .startOfFrame(sof), .oneSecPulse(tick),
        .startGame(sg), .pauseToggle(pt), .loadTime(lt),
        .pixelX(pixelX), .pixelY(pixelY),
        .offsetX(b_offsetX), .offsetY(b_offsetY), .InsideRectangle(b_inside),
        .digit(b_digit), .timeUp(b_timeUp), .timerRunning(b_running)
    );

    always #5 clk = ~clk;

    // Count timeUp pulses seen on instance A
    always @(posedge clk) begin
        if (a_timeUp === 1'b1) n_timeup++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One-cycle pulse on the selected controls, launched from a falling edge
    task automatic pulse(input logic s_sg, input logic s_pt, input logic s_lt,
                         input logic s_tk, input logic s_sof);
        sg = s_sg; pt = s_pt; lt = s_lt; tick = s_tk; sof = s_sof;
        @(negedge clk);
        sg = 1'b0; pt = 1'b0; lt = 1'b0; tick = 1'b0; sof = 1'b0;
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
        end
    endtask

    // Read the displayed MM:SS of both instances by visiting each cell
    task automatic read_time(output logic [15:0] va, output logic [15:0] vb);
        va = 16'h0;
        vb = 16'h0;
        for (int k = 0; k < 4; k++) begin
            pixelX = 11'(283 + k * 20);
            pixelY = 11'd20;
            @(negedge clk);
            va = {va[11:0], a_digit};
            vb = {vb[11:0], b_digit};
        end
    endtask

    // Pixel sweep table: x, y, expected {inside, digit, offsetX, offsetY}
    int          sw_x   [13] = '{279, 280, 295, 296, 299, 300, 320, 355, 356, 375, 340, 340, 340};
    int          sw_y   [13] = '{  8,   8,   8,   8,   8,   8,   8,   8,   8,   8,  39,  40,   7};
    logic        sw_in  [13] = '{  0,   1,   1,   0,   0,   1,   1,   1,   0,   0,   1,   0,   0};
    int          sw_d   [13] = '{  0,   0,   0,   0,   0,   1,   2,   9,   0,   0,   9,   0,   0};
    int          sw_ox  [13] = '{  0,   0,  15,   0,   0,   0,   0,  15,   0,   0,   0,   0,   0};
    int          sw_oy  [13] = '{  0,   0,   0,   0,   0,   0,   0,   0,   0,   0,  31,   0,   0};

    initial begin
        // Reset
        #1 resetN = 1'b0;
        #2;
        check("rst_inside",  {31'd0, a_inside},  32'd0);
        check("rst_offx",    {21'd0, a_offsetX}, 32'd0);
        check("rst_offy",    {21'd0, a_offsetY}, 32'd0);
        check("rst_digit",   {28'd0, a_digit},   32'd0);
        check("rst_timeup",  {31'd0, a_timeUp},  32'd0);
        check("rst_running", {31'd0, a_running}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        read_time(ta, tbv);
        check("init_snap_a", {16'd0, ta},  32'h0200);
        check("init_snap_b", {16'd0, tbv}, 32'h1000);

        // Start and first tick; snapshot must not move until startOfFrame
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("start_running", {31'd0, a_running}, 32'd1);
        do_ticks(1);
        read_time(ta, tbv);
        check("snap_hold_a", {16'd0, ta},  32'h0200);
        check("snap_hold_b", {16'd0, tbv}, 32'h1000);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        read_time(ta, tbv);
        check("tick1_a", {16'd0, ta},  32'h0159);
        check("tick1_b_borrow", {16'd0, tbv}, 32'h0959);
        do_ticks(2);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        read_time(ta, tbv);
        check("tick3_a", {16'd0, ta}, 32'h0157);
        check("tick3_running", {31'd0, a_running}, 32'd1);

        // Pause together with a tick at 01:30
        do_ticks(27);
        pulse(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("pause_running", {31'd0, a_running}, 32'd0);
        do_ticks(5);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        read_time(ta, tbv);
        check("paused_time", {16'd0, ta}, 32'h0129);

        // Output lags pixel input by one cycle (last read left x=343,y=20)
        pixelX = 11'd279;
        pixelY = 11'd8;
        #1;
        check("lag_inside", {31'd0, a_inside},  32'd1);
        check("lag_offx",   {21'd0, a_offsetX}, 32'd3);
        @(negedge clk);
        for (int i = 0; i < 13; i++) begin
            pixelX = 11'(sw_x[i]);
            pixelY = 11'(sw_y[i]);
            @(negedge clk);
            check($sformatf("pix_x%0d_y%0d", sw_x[i], sw_y[i]),
                  {5'd0, a_inside, a_digit, a_offsetX, a_offsetY},
                  {5'd0, sw_in[i], 4'(sw_d[i]), 11'(sw_ox[i]), 11'(sw_oy[i])});
        end

        // Resume and walk the seconds-to-minutes borrow
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("resume_running", {31'd0, a_running}, 32'd1);
        do_ticks(29);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        read_time(ta, tbv);
        check("time_0100", {16'd0, ta}, 32'h0100);
        do_ticks(1);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        read_time(ta, tbv);
        check("borrow_0059", {16'd0, ta}, 32'h0059);
        do_ticks(57);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        read_time(ta, tbv);
        check("time_0002", {16'd0, ta}, 32'h0002);

        // Terminal tick: timeUp exactly one cycle after it
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("tick_0001_no_timeup", {31'd0, a_timeUp}, 32'd0);
        @(negedge clk);
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("timeup_pulse",      {31'd0, a_timeUp},  32'd1);
        check("expired_running",   {31'd0, a_running}, 32'd0);
        @(negedge clk);
        check("timeup_one_cycle",  {31'd0, a_timeUp},  32'd0);
        do_ticks(3);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        read_time(ta, tbv);
        check("expired_0000", {16'd0, ta}, 32'h0000);
        check("single_timeup", n_timeup, 32'd1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("expired_ignore_start", {31'd0, a_running}, 32'd0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("expired_ignore_pause", {31'd0, a_running}, 32'd0);

        // loadTime restores INIT immediately, including the snapshot
        pulse(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("load_running", {31'd0, a_running}, 32'd0);
        read_time(ta, tbv);
        check("load_snap", {16'd0, ta}, 32'h0200);

        // loadTime coinciding with the terminal tick suppresses timeUp
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("restart_running", {31'd0, a_running}, 32'd1);
        do_ticks(119);
        pulse(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("load_tick_timeup",  {31'd0, a_timeUp},  32'd0);
        check("load_tick_running", {31'd0, a_running}, 32'd0);
        @(negedge clk);
        check("load_tick_timeup2", {31'd0, a_timeUp}, 32'd0);
        check("load_tick_count",   n_timeup, 32'd1);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        read_time(ta, tbv);
        check("load_tick_time", {16'd0, ta}, 32'h0200);

        // Asynchronous reset mid-run clears outputs immediately
        pulse(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_ticks(1);
        pixelX = 11'd300;
        pixelY = 11'd20;
        @(negedge clk);
        check("pre_rst_running", {31'd0, a_running}, 32'd1);
        check("pre_rst_inside",  {31'd0, a_inside},  32'd1);
        #2 resetN = 1'b0;
        #1;
        check("mid_rst_outputs",
              {5'd0, a_inside, a_digit, a_offsetX, a_offsetY},
              32'd0);
        check("mid_rst_status", {30'd0, a_running, a_timeUp}, 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        pulse(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        read_time(ta, tbv);
        check("post_rst_time", {16'd0, ta}, 32'h0200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
